// File: rtl/lsu_pkg.sv
// lsu_pkg: store-size encodings, buffered store entry and store-path FSM states
package lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } store_entry_t;
  typedef enum logic {IDLE, ISSUE} state_t;
endpackage

// File: rtl/store_buffer_unit_if.sv
// store_buffer_unit_if: wishbone master bus with master/slave views
interface store_buffer_unit_if;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, cyc_o, lock_o, tgc_o, tgd_o, tga_o;
  logic        ack_i, err_i, rty_i, gnt_i;
  modport master (
    output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, lock_o, tgc_o, tgd_o, tga_o,
    input  ack_i, err_i, rty_i, gnt_i
  );
  modport slave (
    input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, lock_o, tgc_o, tgd_o, tga_o,
    output ack_i, err_i, rty_i, gnt_i
  );
endinterface

// File: rtl/store_buffer_unit_fifo.sv
// store_fifo: synchronous FIFO of aligned store entries; head visible one cycle after push
module store_fifo import lsu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  store_entry_t             wdata_i,
  output store_entry_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  store_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rptr_q];
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: buffers aligned LSU stores and drains them as single wishbone writes
module store_buffer_unit import lsu_pkg::*; #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rstn_i,
  input  logic                req_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  input  logic [1:0]          size_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                misaligned_o,
  output logic                err_o,
  output logic                empty_o,
  store_buffer_unit_if.master wb_bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  state_t       state_q, state_d;
  logic [RW-1:0] rty_q, rty_d;
  store_entry_t in_e, head;
  logic [CW-1:0] count;
  logic         full, fifo_empty, mis, push, pop, stb, rsp_err, rsp_ack, rsp_rty, drop;
  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn_i(rstn_i), .push_i(push), .pop_i(pop), .wdata_i(in_e),
    .rdata_o(head), .full_o(full), .empty_o(fifo_empty), .count_o(count)
  );
  always_comb begin
    mis      = size_i == 2'd3 || (size_i == SIZE_HALF && addr_i[0]) ||
               (size_i == SIZE_WORD && addr_i[1:0] != 2'b00);
    in_e.adr = addr_i;
    in_e.dat = size_i == SIZE_BYTE ? {4{data_i[7:0]}} :
               size_i == SIZE_HALF ? {2{data_i[15:0]}} : data_i;
    in_e.sel = size_i == SIZE_BYTE ? 4'b0001 << addr_i[1:0] :
               size_i == SIZE_HALF ? 4'b0011 << addr_i[1:0] : 4'b1111;
    push     = req_i && !full && !mis;
    stb      = state_q == ISSUE && wb_bus.gnt_i;
    // err beats ack beats rty when a slave raises several at once
    rsp_err  = stb && wb_bus.err_i;
    rsp_ack  = stb && wb_bus.ack_i && !wb_bus.err_i;
    rsp_rty  = stb && wb_bus.rty_i && !wb_bus.ack_i && !wb_bus.err_i;
    drop     = rsp_rty && rty_q == RW'(MAX_RETRY);
    pop      = rsp_err || rsp_ack || drop;
    rty_d    = pop ? '0 : rsp_rty ? rty_q + RW'(1) : rty_q;
    state_d  = state_q == IDLE ? (fifo_empty ? IDLE : ISSUE) :
               (pop && count == CW'(1) && !push) ? IDLE : ISSUE;
  end
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      rty_q   <= rty_d;
    end
  end
  assign wb_bus.cyc_o  = state_q == ISSUE;
  assign wb_bus.we_o   = state_q == ISSUE;
  assign wb_bus.stb_o  = stb;
  assign wb_bus.adr_o  = stb ? head.adr : '0;
  assign wb_bus.dat_o  = stb ? head.dat : '0;
  assign wb_bus.sel_o  = stb ? head.sel : '0;
  assign wb_bus.lock_o = 1'b0;
  assign wb_bus.tgc_o  = 1'b0;
  assign wb_bus.tgd_o  = 1'b0;
  assign wb_bus.tga_o  = 1'b0;
  assign ready_o       = !full;
  assign done_o        = rsp_ack;
  assign err_o         = rsp_err || drop;
  assign misaligned_o  = req_i && mis;
  assign empty_o       = count == '0 && state_q == IDLE;
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
Parametrised successor to the single-word wishbone store path. It accepts byte, halfword and word stores from the LSU into a DEPTH-entry FIFO, so the core does not stall on bus latency. It drains the FIFO to a wishbone master port as single writes and generates byte-lane selects. It also handles bus retry and error responses, and reports completion, misalignment and bus errors back to the core.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
MAX_RETRY, 3, number of reissues after wb_rty_i before the store is dropped with an error; 0 drops on the first retry

Ports:
clk  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_i  in  1  store request; accepted on a cycle where req_i && ready_o
addr_i  in  32  byte address of the store
data_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
size_i  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as misaligned)
ready_o  out  1  FIFO not full
done_o  out  1  one-cycle pulse when the head store is acked on the bus
misaligned_o  out  1  one-cycle pulse in the cycle a request is rejected
err_o  out  1  one-cycle pulse when the head store is dropped (wb_err_i, or retries exhausted)
empty_o  out  1  FIFO empty and no bus transaction in flight (fence/drain indicator)
wb_bus  wb_master_bus_t  -  wishbone master bus; uses ack_i, err_i, rty_i, gnt_i; drives adr_o, dat_o, sel_o, we_o, stb_o, cyc_o; lock_o, tgc_o, tgd_o, tga_o tied to 0

Behaviour:
- Reset: FIFO empty, state IDLE, retry count 0, ready_o = 1, empty_o = 1, all pulses 0, cyc_o/stb_o/we_o = 0, sel_o = 0.
- Reset asserted mid-transaction: buffered stores are discarded and the bus is released immediately.
- Accept: on req_i && ready_o, the request is aligned and pushed. Alignment rules:
  - byte: data replicated to all four lanes; sel = 4'b0001 << addr[1:0]
  - halfword: data replicated to both halves; sel = 4'b0011 << addr[1:0]
  - word: sel = 4'b1111
  - adr_o carries the full addr_i; pushed data is the lane-aligned word.
- Misaligned request is not pushed and pulses misaligned_o in the same cycle. Misaligned means any of: halfword with addr[0] = 1; word with addr[1:0] != 0; size 3.
- ready_o = !full. A push is blocked while full, even if a pop happens in the same cycle. A push when not full while popping is allowed.
- FSM states IDLE, ISSUE:
  - IDLE: cyc_o = 0. Go to ISSUE the cycle after the FIFO becomes non-empty (push takes one cycle to appear at the head).
  - ISSUE: cyc_o = 1, we_o = 1. When gnt_i = 1: stb_o = 1 and adr/dat/sel are driven from the head entry; while gnt_i = 0, stb_o = 0 and sel_o = 0.
  - ISSUE, same cycle as stb_o:
    - ack_i: pop the head, pulse done_o, clear the retry count.
    - err_i: pop the head, pulse err_o, clear the retry count.
    - rty_i with retry count < MAX_RETRY: increment the count, keep the head, reissue next cycle.
    - rty_i with count == MAX_RETRY: pop the head, pulse err_o, clear the count.
  - ISSUE exit: after a pop, if the FIFO is then empty and there is no same-cycle push, go to IDLE. Otherwise stay in ISSUE, holding cyc_o through back-to-back stores.
- Response priority when several responses arrive together: err_i > ack_i > rty_i.
- Responses arriving while stb_o = 0 are ignored.
- Zero-wait slaves are supported: ack_i in the same cycle as stb_o gives one store per cycle.
- empty_o = (count == 0) && state == IDLE.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package lsu_pkg: size encodings (SIZE_BYTE/HALF/WORD), typedef store_entry_t {adr[31:0], dat[31:0], sel[3:0]}, and the state enum.
- Sub-module store_fifo: synchronous FIFO of store_entry_t, parametrised on DEPTH, with push/pop/full/empty/count.
- All alignment logic and the FSM stay in store_buffer_unit.

Test Plan:
- Byte store: addr 0x1003, data 0xAB, size 0, gnt=1, ack one cycle after stb -> stb with adr 0x1003, sel 4'b1000, dat 0xABABABAB; done_o pulse; empty_o back to 1.
- Fill: 4 word stores to 0x100, 0x104, 0x108, 0x10C with gnt=0 -> ready_o falls after the 4th; a 5th req is not accepted. Then gnt=1 with zero-wait ack -> four consecutive stb cycles in order, cyc_o held throughout, 4 done_o pulses.
- Misaligned: halfword at 0x2001 and word at 0x2002 -> misaligned_o pulse on each, no bus activity, empty_o stays 1.
- Retry: MAX_RETRY=3, slave returns rty 3 times then ack -> 4 stb beats with identical adr/dat, done_o once, no err_o. Repeat with 4 rtys -> err_o once after the 4th, entry dropped, next store proceeds.
- Error: err_i on the first of two queued stores -> err_o pulse, the second store issues the next cycle and completes with done_o.
- Reset mid-burst: 3 stores queued, rstn_i low during an active stb -> cyc_o/stb_o = 0 immediately; after release ready_o = 1, empty_o = 1, no stale writes issued.
